// File: rtl/dpram_stream_fifo.sv
// Valid/ready FIFO controller in front of a dual-port RAM (port 1 write, port 2 read).
// A 2-entry output buffer hides the 1-cycle RAM read latency, giving first-word-fall-through output.
module dpram_stream_fifo #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_INC  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [ADDR_WIDTH:0]   r_ramCnt;
    logic                  r_inflight;
    occ_t                  r_occ;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [1:0]            w_occBits;
    logic [2:0]            w_slots;

    assign w_occBits = r_occ;

    assign wr_ready  = (r_ramCnt != FULL_CNT);
    assign w_push    = wr_valid && wr_ready;
    assign ram_we    = w_push;
    assign ram_waddr = r_wptr[ADDR_WIDTH-1:0];
    assign ram_wdata = wr_data;
    assign ram_raddr = r_rptr[ADDR_WIDTH-1:0];

    assign rd_valid  = (r_occ != EMPTY);
    assign rd_data   = r_head;
    assign w_pop     = rd_valid && rd_ready;

    // A read is issued only if its word will have a buffer slot when it returns.
    assign w_slots   = {1'b0, w_occBits} + {2'b00, r_inflight};
    assign w_issue   = (r_ramCnt != '0) && (w_slots < (3'd2 + {2'b00, w_pop}));

    assign count = {1'b0, r_ramCnt}
                 + {{(ADDR_WIDTH+1){1'b0}}, r_inflight}
                 + {{ADDR_WIDTH{1'b0}}, w_occBits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ramCnt   <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_INC;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + PTR_INC;
            end
            r_inflight <= w_issue;
            case ({w_push, w_issue})
                2'b10:   r_ramCnt <= r_ramCnt + PTR_INC;
                2'b01:   r_ramCnt <= r_ramCnt - PTR_INC;
                default: r_ramCnt <= r_ramCnt;
            endcase
        end
    end

    // Head is the registered output word; tail only holds the second word in TWO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_occ)
                EMPTY: begin
                    if (r_inflight) begin
                        r_head <= ram_rdata;
                        r_occ  <= ONE;
                    end
                end
                ONE: begin
                    if (r_inflight && w_pop) begin
                        r_head <= ram_rdata;
                    end else if (r_inflight) begin
                        r_tail <= ram_rdata;
                        r_occ  <= TWO;
                    end else if (w_pop) begin
                        r_occ  <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_occ  <= ONE;
                    end
                end
                default: r_occ <= EMPTY;
            endcase
        end
    end

    a_noCaptureWhenFull: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_occ == TWO && r_inflight));

    a_cntMatchesPtrs: assert property (@(posedge clk) disable iff (!rst_n)
        r_ramCnt == (r_wptr - r_rptr));

endmodule

// File: tb/tb_dpram_stream_fifo.sv
// Directed and randomised checks for dpram_stream_fifo, driving a behavioural
// dual-port RAM with a registered read port.
module tb_dpram_stream_fifo;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW+1:0] count;
    logic [AW-1:0] ram_waddr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [DEPTH];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dpram_stream_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .count     (count),
        .ram_waddr (ram_waddr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    // Behavioural RAM macro: port 1 writes, port 2 reads with one cycle of latency.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_raddr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd, input logic rr);
        @(negedge clk);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad;
        int gaps;
        int over;
        int popped;
        int firstValid;
        int cntBad;
        int stabBad;
        logic [DW-1:0] expNext;
        logic [DW-1:0] pushData;
        logic [DW-1:0] prevData;
        logic [DW-1:0] q[$];
        logic stalledPrev;
        logic wv;
        logic rr;

        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset held for three cycles
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_wr_ready", 64'(wr_ready), 64'd1);
        checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("reset_count",    64'(count),    64'd0);
        checkOutput("reset_ram_we",   64'(ram_we),   64'd0);
        checkOutput("reset_rd_data",  64'(rd_data),  64'd0);

        // Single word latency: push at t, visible at t+3, gone at t+4
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
        checkOutput("single_ram_we",    64'(ram_we),    64'd1);
        checkOutput("single_ram_waddr", 64'(ram_waddr), 64'd0);
        checkOutput("single_count_t0",  64'(count),     64'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_raddr_t1",  64'(ram_raddr), 64'd0);
        checkOutput("single_count_t1",  64'(count),     64'd1);
        checkOutput("single_valid_t1",  64'(rd_valid),  64'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_raddr_t2",  64'(ram_raddr), 64'd1);
        checkOutput("single_valid_t2",  64'(rd_valid),  64'd0);
        checkOutput("single_count_t2",  64'(count),     64'd1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_valid_t3",  64'(rd_valid),  64'd1);
        checkOutput("single_data_t3",   64'(rd_data),   64'hDEADBEEF);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("single_count_t4",  64'(count),     64'd0);
        checkOutput("single_valid_t4",  64'(rd_valid),  64'd0);

        // Fill to DEPTH+2 without popping
        bad = 0;
        for (int i = 1; i <= DEPTH + 2; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b0);
            if (!wr_ready || !ram_we) bad++;
        end
        checkOutput("fill_accept_all", 64'(bad), 64'd0);
        applyStimulus(1'b1, DW'(DEPTH + 3), 1'b0);
        checkOutput("full_wr_ready", 64'(wr_ready), 64'd0);
        checkOutput("full_ram_we",   64'(ram_we),   64'd0);
        checkOutput("full_count",    64'(count),    64'(DEPTH + 2));
        checkOutput("full_head",     64'(rd_data),  64'd1);

        // Drain: one word per cycle, in order, no bubbles
        bad = 0;
        for (int i = 1; i <= DEPTH + 2; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (!rd_valid || rd_data != DW'(i)) bad++;
        end
        checkOutput("drain_order", 64'(bad), 64'd0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("drain_empty_valid", 64'(rd_valid), 64'd0);
        checkOutput("drain_empty_count", 64'(count),    64'd0);
        checkOutput("drain_wr_ready",    64'(wr_ready), 64'd1);

        // Streaming with pointer wrap
        expNext    = 32'd5000;
        pushData   = 32'd5000;
        firstValid = -1;
        bad = 0; gaps = 0; over = 0; popped = 0;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(1'b1, pushData, 1'b1);
            if (ram_we) pushData++;
            if (count > 12'd3) over++;
            if (rd_valid) begin
                if (firstValid < 0) firstValid = c;
                if (rd_data != expNext) bad++;
                expNext++;
                popped++;
            end else if (firstValid >= 0) begin
                gaps++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (rd_valid) begin
                if (rd_data != expNext) bad++;
                expNext++;
                popped++;
            end
        end
        checkOutput("stream_first_valid", 64'(firstValid), 64'd3);
        checkOutput("stream_data",        64'(bad),        64'd0);
        checkOutput("stream_gaps",        64'(gaps),       64'd0);
        checkOutput("stream_count_le3",   64'(over),       64'd0);
        checkOutput("stream_popped",      64'(popped),     64'd3000);
        checkOutput("stream_end_count",   64'(count),      64'd0);

        // Random backpressure against a queue scoreboard
        bad = 0; cntBad = 0; stabBad = 0;
        stalledPrev = 1'b0;
        prevData    = '0;
        for (int c = 0; c < 20000; c++) begin
            wv = ($urandom_range(99) < 70);
            rr = ($urandom_range(99) < 30);
            applyStimulus(wv, $urandom, rr);
            if (int'(count) != q.size()) cntBad++;
            if (stalledPrev && rd_data != prevData) stabBad++;
            if (rd_valid && rd_ready) begin
                if (q.size() == 0) bad++;
                else if (rd_data != q.pop_front()) bad++;
            end
            if (wr_valid && wr_ready) q.push_back(wr_data);
            stalledPrev = rd_valid && !rd_ready;
            prevData    = rd_data;
        end
        for (int c = 0; c < DEPTH + 20; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (rd_valid) begin
                if (q.size() == 0) bad++;
                else if (rd_data != q.pop_front()) bad++;
            end
        end
        checkOutput("bp_scoreboard",   64'(bad),      64'd0);
        checkOutput("bp_count_track",  64'(cntBad),   64'd0);
        checkOutput("bp_stall_stable", 64'(stabBad),  64'd0);
        checkOutput("bp_queue_empty",  64'(q.size()), 64'd0);
        checkOutput("bp_end_valid",    64'(rd_valid), 64'd0);

        // Asynchronous reset while holding 500 words
        for (int i = 0; i < 500; i++) applyStimulus(1'b1, DW'(i + 100), 1'b0);
        repeat (4) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("pre_reset_count", 64'(count), 64'd500);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid",    64'(rd_valid), 64'd0);
        checkOutput("async_rst_count",    64'(count),    64'd0);
        checkOutput("async_rst_wr_ready", 64'(wr_ready), 64'd1);
        checkOutput("async_rst_rd_data",  64'(rd_data),  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h5, 1'b0);
        checkOutput("post_rst_waddr", 64'(ram_waddr), 64'd0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_rst_valid_t1", 64'(rd_valid), 64'd0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_rst_valid_t2", 64'(rd_valid), 64'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("post_rst_valid_t3", 64'(rd_valid), 64'd1);
        checkOutput("post_rst_data_t3",  64'(rd_data),  64'h5);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_rst_count_end", 64'(count),    64'd0);
        checkOutput("post_rst_valid_end", 64'(rd_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
